// File: rtl/fifo_uart_pkg.sv
// Shared types and helpers for the FIFO-fed UART transmitter.
// Optional parity state is present only when FIFO_UART_TX_PARITY_EN is defined.
package fifo_uart_pkg;

    localparam logic IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        LATCH,
        START,
        DATA,
`ifdef FIFO_UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    function automatic int calc_baud_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    function automatic int calc_cnt_width(input int baud_div);
        return (baud_div > 1) ? $clog2(baud_div) : 1;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..BAUD_DIV-1 while enabled and flags the terminal count.
module uart_baud_cnt
    import fifo_uart_pkg::*;
#(
    parameter int BAUD_DIV = 434
) (
    input  logic sclk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = calc_cnt_width(BAUD_DIV);
    localparam logic [CW-1:0] TERMINAL = CW'(BAUD_DIV - 1);

    logic [CW-1:0] cnt_reg;

    assign tick = en && (cnt_reg == TERMINAL);

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (en) begin
            cnt_reg <= tick ? '0 : cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains bytes from the sync FIFO and sends them 8N1, LSB first, on a flop-driven tx line.
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200
) (
    input  logic       sclk,
    input  logic       rst_n,
    input  logic       tx_en,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_dout,
    output logic       fifo_rd,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);

    localparam int BAUD_DIV = calc_baud_div(CLK_FREQ, BAUD);

    if (BAUD_DIV < 4) begin : g_baud_div_check
        $error("fifo_uart_tx: CLK_FREQ/BAUD must be at least 4");
    end

    state_t     state_reg, state_next;
    logic [7:0] shift_reg, shift_next;
    logic [2:0] bit_cnt_reg, bit_cnt_next;
    logic       tx_reg, tx_next;
    logic       rd_reg, rd_next;
    logic       busy_reg, busy_next;
    logic       done_reg, done_next;
`ifdef FIFO_UART_TX_PARITY_EN
    logic       parity_reg, parity_next;
`endif
    logic       baud_en, baud_tick;

    // The bit timer only runs once the start bit is on the line.
    assign baud_en = (state_reg != IDLE) && (state_reg != RD) && (state_reg != LATCH);

    uart_baud_cnt #(
        .BAUD_DIV(BAUD_DIV)
    ) u_baud_cnt (
        .sclk (sclk),
        .rst_n(rst_n),
        .en   (baud_en),
        .clr  (!baud_en),
        .tick (baud_tick)
    );

    always_comb begin
        state_next   = state_reg;
        shift_next   = shift_reg;
        bit_cnt_next = bit_cnt_reg;
        tx_next      = tx_reg;
        rd_next      = 1'b0;
        busy_next    = busy_reg;
        done_next    = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
        parity_next  = parity_reg;
`endif
        case (state_reg)
            IDLE: begin
                tx_next = IDLE_LEVEL;
                if (tx_en && !fifo_empty) begin
                    rd_next    = 1'b1;
                    busy_next  = 1'b1;
                    state_next = RD;
                end
            end
            RD: state_next = LATCH;
            LATCH: begin
                shift_next   = fifo_dout;
                tx_next      = 1'b0;
                bit_cnt_next = 3'd0;
`ifdef FIFO_UART_TX_PARITY_EN
                parity_next  = ^fifo_dout;
`endif
                state_next   = START;
            end
            START: begin
                if (baud_tick) begin
                    tx_next    = shift_reg[0];
                    state_next = DATA;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    shift_next   = shift_reg >> 1;
                    bit_cnt_next = bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7) begin
`ifdef FIFO_UART_TX_PARITY_EN
                        tx_next    = parity_reg;
                        state_next = PARITY;
`else
                        tx_next    = IDLE_LEVEL;
                        state_next = STOP;
`endif
                    end else begin
                        // shift_reg[0] is the bit currently on the line.
                        tx_next = shift_reg[1];
                    end
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY: begin
                if (baud_tick) begin
                    tx_next    = IDLE_LEVEL;
                    state_next = STOP;
                end
            end
`endif
            STOP: begin
                tx_next = IDLE_LEVEL;
                if (baud_tick) begin
                    done_next  = 1'b1;
                    busy_next  = 1'b0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
            tx_reg      <= IDLE_LEVEL;
            rd_reg      <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_reg  <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            shift_reg   <= shift_next;
            bit_cnt_reg <= bit_cnt_next;
            tx_reg      <= tx_next;
            rd_reg      <= rd_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_reg  <= parity_next;
`endif
        end
    end

    assign tx      = tx_reg;
    assign fifo_rd = rd_reg;
    assign busy    = busy_reg;
    assign tx_done = done_reg;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx: a queue-backed FIFO model feeds bytes and every
// frame on tx is compared cycle by cycle against the bit pattern derived from the byte.
module tb_fifo_uart_tx;

    localparam int CLK_FREQ = 1000;
    localparam int BAUD     = 100;
    localparam int DIV      = CLK_FREQ / BAUD;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * DIV;
    // Back-to-back: 3 idle-high cycles; the first is consumed by the end-of-frame sample.
    localparam int GAP_SAMPLES = 2;
    localparam int MAX_WAIT    = 60;

    logic       sclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tx_en = 1'b0;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_dout = 8'h00;
    logic       fifo_rd, tx, busy, tx_done;

    int checks = 0;
    int errors = 0;

    logic [7:0] fifo_q[$];
    int rd_pulses = 0;
    int rd_run    = 0;
    int rd_bad    = 0;
    int done_cnt  = 0;

    fifo_uart_tx #(
        .CLK_FREQ(CLK_FREQ),
        .BAUD    (BAUD)
    ) dut (
        .sclk      (sclk),
        .rst_n     (rst_n),
        .tx_en     (tx_en),
        .fifo_empty(fifo_empty),
        .fifo_dout (fifo_dout),
        .fifo_rd   (fifo_rd),
        .tx        (tx),
        .busy      (busy),
        .tx_done   (tx_done)
    );

    always #5 sclk = ~sclk;

    // FIFO model: registered empty flag, data valid the cycle after a sampled read.
    always @(posedge sclk) begin
        if (fifo_rd && !fifo_empty && fifo_q.size() > 0) begin
            fifo_dout <= fifo_q.pop_front();
        end
        fifo_empty <= (fifo_q.size() == 0);
    end

    // Pulse monitor, sampled away from the active edge.
    always @(negedge sclk) begin
        if (fifo_rd === 1'b1) begin
            if (rd_run == 0) rd_pulses++;
            rd_run++;
        end else begin
            if (rd_run > 1) rd_bad++;
            rd_run = 0;
        end
        if (tx_done === 1'b1) done_cnt++;
    end

    task automatic expect_frame(input logic [7:0] b, input int drop_at, input int gap_req,
                                input string tag);
        logic [NBITS-1:0] bits;
        int w;
        logic bad;
        logic act_tx, act_busy, act_done;
        bits = '0;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = b[i];
`ifdef FIFO_UART_TX_PARITY_EN
        bits[9] = ^b;
`endif
        bits[NBITS-1] = 1'b1;
        w = 0;
        @(negedge sclk);
        while (tx !== 1'b0 && w < MAX_WAIT) begin
            w++;
            @(negedge sclk);
        end
        checks++;
        if (tx !== 1'b0) begin
            errors++;
            $display("FAIL %s start: tx=%b after %0d cycles, required falling edge", tag, tx, w);
            return;
        end
        if (gap_req >= 0) begin
            checks++;
            if (w != gap_req) begin
                errors++;
                $display("FAIL %s gap: %0d idle samples, required %0d", tag, w, gap_req);
            end
        end
        for (int bi = 0; bi < NBITS; bi++) begin
            bad = 1'b0;
            act_tx = 1'b0; act_busy = 1'b0; act_done = 1'b0;
            for (int c = 0; c < DIV; c++) begin
                if (bi != 0 || c != 0) @(negedge sclk);
                if (bi * DIV + c == drop_at) tx_en = 1'b0;
                if (!bad && (tx !== bits[bi] || busy !== 1'b1 || tx_done !== 1'b0)) begin
                    bad = 1'b1;
                    act_tx = tx; act_busy = busy; act_done = tx_done;
                end
            end
            checks++;
            if (bad) begin
                errors++;
                $display("FAIL %s byte %02h bit%0d: tx=%b busy=%b done=%b, required tx=%b busy=1 done=0",
                         tag, b, bi, act_tx, act_busy, act_done, bits[bi]);
            end
        end
        @(negedge sclk);
        checks++;
        if (tx_done !== 1'b1 || busy !== 1'b0 || tx !== 1'b1) begin
            errors++;
            $display("FAIL %s end: tx_done=%b busy=%b tx=%b, required 1 0 1", tag, tx_done, busy, tx);
        end
    endtask

    task automatic check_counts(input string tag, input int rd_base, input int rd_exp,
                                input int done_base, input int done_exp);
        @(negedge sclk);
        checks++;
        if (rd_pulses - rd_base != rd_exp || rd_bad != 0) begin
            errors++;
            $display("FAIL %s reads: %0d pulses (%0d too wide), required %0d single-cycle",
                     tag, rd_pulses - rd_base, rd_bad, rd_exp);
        end
        checks++;
        if (done_cnt - done_base != done_exp) begin
            errors++;
            $display("FAIL %s tx_done: %0d pulses, required %0d", tag, done_cnt - done_base, done_exp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge sclk);
        checks++;
        if (tx !== 1'b1 || fifo_rd !== 1'b0 || busy !== 1'b0 || tx_done !== 1'b0) begin
            errors++;
            $display("FAIL reset: tx=%b fifo_rd=%b busy=%b tx_done=%b, required 1 0 0 0",
                     tx, fifo_rd, busy, tx_done);
        end
        rst_n = 1'b1;
        @(negedge sclk);
    endtask

    task automatic test_single();
        int rb, db;
        rb = rd_pulses; db = done_cnt;
        fifo_q.push_back(8'hA5);
        tx_en = 1'b1;
        expect_frame(8'hA5, -1, -1, "single");
        check_counts("single", rb, 1, db, 1);
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq [3];
        int rb, db;
        seq[0] = 8'h00; seq[1] = 8'hFF; seq[2] = 8'h3C;
        rb = rd_pulses; db = done_cnt;
        for (int i = 0; i < 3; i++) fifo_q.push_back(seq[i]);
        for (int i = 0; i < 3; i++) expect_frame(seq[i], -1, (i == 0) ? -1 : GAP_SAMPLES, "b2b");
        check_counts("b2b", rb, 3, db, 3);
    endtask

    task automatic test_random();
        logic [7:0] seq [5];
        int rb, db;
        rb = rd_pulses; db = done_cnt;
        for (int i = 0; i < 5; i++) begin
            seq[i] = 8'($urandom_range(0, 255));
            fifo_q.push_back(seq[i]);
        end
        for (int i = 0; i < 5; i++) expect_frame(seq[i], -1, (i == 0) ? -1 : GAP_SAMPLES, "random");
        check_counts("random", rb, 5, db, 5);
    endtask

    task automatic test_empty();
        int rb;
        logic bad;
        rb = rd_pulses;
        bad = 1'b0;
        tx_en = 1'b1;
        repeat (500) begin
            @(negedge sclk);
            if (fifo_rd !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad || rd_pulses != rb) begin
            errors++;
            $display("FAIL empty: activity with empty FIFO (%0d reads), required none", rd_pulses - rb);
        end
    endtask

    task automatic test_tx_en_drop();
        logic [7:0] b0, b1;
        int rb;
        logic bad;
        b0 = 8'($urandom_range(0, 255));
        b1 = 8'($urandom_range(0, 255));
        rb = rd_pulses;
        fifo_q.push_back(b0);
        fifo_q.push_back(b1);
        tx_en = 1'b1;
        expect_frame(b0, 40, -1, "en_drop");
        bad = 1'b0;
        repeat (200) begin
            @(negedge sclk);
            if (fifo_rd !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad || rd_pulses - rb != 1 || fifo_q.size() != 1) begin
            errors++;
            $display("FAIL en_drop hold: %0d reads, %0d queued, required 1 read and 1 queued",
                     rd_pulses - rb, fifo_q.size());
        end
        tx_en = 1'b1;
        expect_frame(b1, -1, -1, "en_resume");
    endtask

    task automatic test_reset_mid();
        logic [7:0] b0, b1;
        int w, rb;
        b0 = 8'($urandom_range(0, 255));
        b1 = 8'($urandom_range(0, 255));
        rb = rd_pulses;
        fifo_q.push_back(b0);
        fifo_q.push_back(b1);
        tx_en = 1'b1;
        w = 0;
        @(negedge sclk);
        while (tx !== 1'b0 && w < MAX_WAIT) begin
            w++;
            @(negedge sclk);
        end
        repeat (55) @(negedge sclk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || fifo_rd !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid: tx=%b busy=%b fifo_rd=%b, required 1 0 0 before next edge",
                     tx, busy, fifo_rd);
        end
        @(negedge sclk);
        rst_n = 1'b1;
        expect_frame(b1, -1, -1, "rst_after");
        checks++;
        if (rd_pulses - rb != 2 || fifo_q.size() != 0) begin
            errors++;
            $display("FAIL rst_mid reads: %0d reads, %0d queued, required 2 and 0",
                     rd_pulses - rb, fifo_q.size());
        end
    endtask

`ifdef FIFO_UART_TX_PARITY_EN
    task automatic test_parity();
        int rb, db;
        rb = rd_pulses; db = done_cnt;
        fifo_q.push_back(8'hA5);
        fifo_q.push_back(8'h07);
        tx_en = 1'b1;
        expect_frame(8'hA5, -1, -1, "parity_a5");
        expect_frame(8'h07, -1, GAP_SAMPLES, "parity_07");
        check_counts("parity", rb, 2, db, 2);
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_random();
        test_empty();
        test_tx_en_drop();
        test_reset_mid();
`ifdef FIFO_UART_TX_PARITY_EN
        test_parity();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
